// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage.
//   funct3_e  : load/store width and sign encodings
//   state_e   : memory-access FSM states
//   w_reg_t   : contents of the W pipeline register
//   access_fault() : flags illegal widths and misaligned addresses
package mem_wb_stage_pkg;

  localparam int DEPTH_WORDS_DEF = 256;
  localparam int WAIT_STATES_DEF = 1;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
  } w_reg_t;

  // Returns 1 when an access with this funct3/address cannot be performed.
  function automatic logic access_fault(logic [2:0] f3, logic [1:0] a);
    logic f;
    case (f3)
      F3_B, F3_BU: f = 1'b0;
      F3_H, F3_HU: f = a[0];
      F3_W:        f = (a != 2'b00);
      default:     f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// M-stage request / W-stage result bundle for mem_wb_stage.
//   slave  : the stage itself (consumes M inputs, drives stall/fault/W)
//   master : the surrounding pipeline
interface mem_wb_stage_if;
  logic        iRegWriteM;
  logic        iMemToRegM;
  logic        iMemWriteM;
  logic [2:0]  iFunct3M;
  logic [31:0] iALUOutM;
  logic [31:0] iWriteDataM;
  logic [4:0]  iWriteRegM;
  logic        iFlushW;
  logic        oStallM;
  logic        oFaultM;
  logic        oRegWriteW;
  logic        oMemToRegW;
  logic [31:0] oReadDataW;
  logic [31:0] oALUOutW;
  logic [4:0]  oWriteRegW;

  modport slave (
    input  iRegWriteM, iMemToRegM, iMemWriteM, iFunct3M, iALUOutM,
           iWriteDataM, iWriteRegM, iFlushW,
    output oStallM, oFaultM, oRegWriteW, oMemToRegW, oReadDataW,
           oALUOutW, oWriteRegW
  );

  modport master (
    output iRegWriteM, iMemToRegM, iMemWriteM, iFunct3M, iALUOutM,
           iWriteDataM, iWriteRegM, iFlushW,
    input  oStallM, oFaultM, oRegWriteW, oMemToRegW, oReadDataW,
           oALUOutW, oWriteRegW
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// load_align: picks the addressed byte/half out of a RAM word and
// sign- or zero-extends it according to funct3. Purely combinational.
//   word_i   : full 32-bit RAM word
//   off_i    : byte offset within the word
//   funct3_i : load width/sign
//   data_o   : value to write back
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*off_i +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access with a fixed number of wait states,
// followed by the W pipeline register.
//   iClk, iRst : clock, async active-high reset
//   bus        : M-stage request in, stall/fault and W register out
// An access stalls for WAIT_STATES cycles and commits (RAM write or
// load capture into W) in the first cycle oStallM is low again.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input logic           iClk,
  input logic           iRst,
  mem_wb_stage_if.slave bus
);

  localparam int AW       = $clog2(DEPTH_WORDS);
  localparam int CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam bit HAS_WAIT = (WAIT_STATES != 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  w_reg_t             w_q, w_d;

  logic               access, fault, valid;
  logic               stall, commit, pass;
  logic [AW-1:0]      ram_idx;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic [31:0]        rd_word, ld_data;
  logic [3:0][7:0]    mem_q [DEPTH_WORDS];
  logic               unused_addr;

  // Address bits above the RAM index are ignored, so accesses wrap.
  assign unused_addr = ^bus.iALUOutM[31:AW+2];

  assign access = bus.iMemToRegM | bus.iMemWriteM;
  assign fault  = access & access_fault(bus.iFunct3M, bus.iALUOutM[1:0]);
  assign valid  = access & ~fault;

  // ---- FSM: state register ----
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (valid && HAS_WAIT) begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(WAIT_STATES - 1);
      end
      ST_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
               else             state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // Reset masks stall/fault so the outputs are quiet while iRst is high,
  // and blocks commit so a store pending at reset never lands.
  always_comb begin
    stall  = 1'b0;
    commit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall  = valid & HAS_WAIT;
        commit = valid & ~HAS_WAIT;
      end
      ST_WAIT: begin
        stall  = (cnt_q != '0);
        commit = (cnt_q == '0);
      end
      default: ;
    endcase
    stall  = stall  & ~iRst;
    commit = commit & ~iRst;
  end

  // ---- data RAM ----
  assign ram_idx = bus.iALUOutM[AW+1:2];
  assign rd_word = mem_q[ram_idx];

  always_comb begin
    case (bus.iFunct3M[1:0])
      2'd0: begin
        be    = 4'b0001 << bus.iALUOutM[1:0];
        wdata = {4{bus.iWriteDataM[7:0]}};
      end
      2'd1: begin
        be    = bus.iALUOutM[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.iWriteDataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.iWriteDataM;
      end
    endcase
    if (!(commit && bus.iMemWriteM)) be = 4'b0000;
  end

  // RAM contents survive reset.
  always_ff @(posedge iClk) begin
    for (int l = 0; l < 4; l++)
      if (be[l]) mem_q[ram_idx][l] <= wdata[8*l +: 8];
  end

  load_align u_load_align (
    .word_i   (rd_word),
    .off_i    (bus.iALUOutM[1:0]),
    .funct3_i (bus.iFunct3M),
    .data_o   (ld_data)
  );

  // ---- W register ----
  // When not stalled and not faulting, a valid access is committing, so
  // the only remaining bubble source is iFlushW.
  assign pass = ~stall & ~(fault & ~iRst) & ~bus.iFlushW;

  always_comb begin
    w_d = w_q;
    if (pass) begin
      w_d.reg_write  = bus.iRegWriteM;
      w_d.mem_to_reg = bus.iMemToRegM;
      w_d.read_data  = bus.iMemToRegM ? ld_data : 32'h0;
      w_d.alu_out    = bus.iALUOutM;
      w_d.write_reg  = bus.iWriteRegM;
    end else begin
      w_d.reg_write  = 1'b0;
      w_d.mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) w_q <= '0;
    else      w_q <= w_d;
  end

  assign bus.oStallM    = stall;
  assign bus.oFaultM    = fault & ~iRst;
  assign bus.oRegWriteW = w_q.reg_write;
  assign bus.oMemToRegW = w_q.mem_to_reg;
  assign bus.oReadDataW = w_q.read_data;
  assign bus.oALUOutW   = w_q.alu_out;
  assign bus.oWriteRegW = w_q.write_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: one instance with two wait
// states, one with none. A byte-array memory model and the width/
// alignment rules predict stall length, fault, W contents and load data.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int DW = 256;
  localparam int NB = DW * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if b2 ();
  mem_wb_stage_if b0 ();

  mem_wb_stage #(.DEPTH_WORDS(DW), .WAIT_STATES(2)) dut2 (
    .iClk(clk), .iRst(rst), .bus(b2.slave));
  mem_wb_stage #(.DEPTH_WORDS(DW), .WAIT_STATES(0)) dut0 (
    .iClk(clk), .iRst(rst), .bus(b0.slave));

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] mm [2][NB];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // d=0 selects the two-wait-state instance, d=1 the zero-wait one.
  task automatic drive(bit d, logic rw, logic mtr, logic mw, logic [2:0] f3,
                       logic [31:0] a, logic [31:0] wd, logic [4:0] rd, logic fl);
    if (d) begin
      b0.iRegWriteM = rw; b0.iMemToRegM = mtr; b0.iMemWriteM = mw;
      b0.iFunct3M = f3; b0.iALUOutM = a; b0.iWriteDataM = wd;
      b0.iWriteRegM = rd; b0.iFlushW = fl;
    end else begin
      b2.iRegWriteM = rw; b2.iMemToRegM = mtr; b2.iMemWriteM = mw;
      b2.iFunct3M = f3; b2.iALUOutM = a; b2.iWriteDataM = wd;
      b2.iWriteRegM = rd; b2.iFlushW = fl;
    end
  endtask

  task automatic nop(bit d);
    drive(d, 0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 0);
  endtask

  function automatic logic stall_of(bit d);
    return d ? b0.oStallM : b2.oStallM;
  endfunction

  function automatic logic fault_of(bit d);
    return d ? b0.oFaultM : b2.oFaultM;
  endfunction

  task automatic read_w(bit d, output logic rw, output logic mtr,
                        output logic [31:0] rdat, output logic [31:0] alu,
                        output logic [4:0] rd);
    if (d) begin
      rw = b0.oRegWriteW; mtr = b0.oMemToRegW; rdat = b0.oReadDataW;
      alu = b0.oALUOutW; rd = b0.oWriteRegW;
    end else begin
      rw = b2.oRegWriteW; mtr = b2.oMemToRegW; rdat = b2.oReadDataW;
      alu = b2.oALUOutW; rd = b2.oWriteRegW;
    end
  endtask

  // Presents one instruction at posedge+1, holds it through the stall and
  // checks the W register one edge after the commit.
  task automatic run_op(bit d, logic rw, logic mtr, logic mw, logic [2:0] f3,
                        logic [31:0] a, logic [31:0] wd, logic [4:0] rd,
                        logic fl, output logic [31:0] rdat);
    int ws, stalls, sz, b;
    bit acc, legal, flt, bub;
    logic [31:0] exp_rd;
    logic g_rw, g_mtr;
    logic [31:0] g_alu;
    logic [4:0] g_rd;
    ws     = d ? 0 : 2;
    stalls = 0;
    acc    = mtr | mw;
    legal  = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    sz     = 1 << (f3 % 4);
    flt    = acc && (!legal || (a % sz) != 0);
    drive(d, rw, mtr, mw, f3, a, wd, rd, fl);
    #1;
    chk("fault", 32'(fault_of(d)), 32'(flt));
    while (stall_of(d) && stalls < 10) begin
      stalls++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", 32'(stalls), (acc && !flt) ? 32'(ws) : 32'd0);
    b = int'(a & 32'(NB - 1));
    exp_rd = 32'h0;
    if (acc && !flt) begin
      if (mw) begin
        for (int k = 0; k < sz; k++) mm[d][b+k] = 8'(wd >> (8*k));
      end else begin
        for (int k = 0; k < sz; k++) exp_rd |= 32'(mm[d][b+k]) << (8*k);
        if (f3 < 4 && sz < 4 && exp_rd[8*sz-1]) exp_rd |= 32'hFFFF_FFFF << (8*sz);
      end
    end
    @(posedge clk); #1;
    bub = flt || fl;
    read_w(d, g_rw, g_mtr, rdat, g_alu, g_rd);
    chk("w_regwrite", 32'(g_rw), bub ? 32'd0 : 32'(rw));
    chk("w_memtoreg", 32'(g_mtr), bub ? 32'd0 : 32'(mtr));
    if (!bub) begin
      chk("w_aluout", g_alu, a);
      chk("w_writereg", 32'(g_rd), 32'(rd));
      if (mtr) chk("w_readdata", rdat, exp_rd);
    end
    nop(d);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_stall"}, 32'(b2.oStallM), 32'd0);
    chk({tag, "_fault"}, 32'(b2.oFaultM), 32'd0);
    chk({tag, "_regwrite"}, 32'(b2.oRegWriteW), 32'd0);
    chk({tag, "_memtoreg"}, 32'(b2.oMemToRegW), 32'd0);
    chk({tag, "_readdata"}, b2.oReadDataW, 32'd0);
    chk({tag, "_aluout"}, b2.oALUOutW, 32'd0);
    chk({tag, "_writereg"}, 32'(b2.oWriteRegW), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  f3;
    logic [31:0] a;
    int kind, sz;
    bit d;

    rst = 1'b1;
    nop(0); nop(1);
    #1;
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill both RAMs so every later load has a defined value.
    for (int i = 0; i < DW; i++) begin
      run_op(0, 0, 0, 1, 3'd2, 32'(4*i), $urandom, 5'd0, 0, r);
      run_op(1, 0, 0, 1, 3'd2, 32'(4*i), $urandom, 5'd0, 0, r);
    end

    // Word store/load round trip.
    run_op(0, 0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0, 0, r);
    run_op(0, 1, 1, 0, 3'd2, 32'h10, 32'h0, 5'd3, 0, r);
    chk("lw_deadbeef", r, 32'hDEADBEEF);

    // Byte store, signed/unsigned byte loads, merged word.
    run_op(0, 0, 0, 1, 3'd0, 32'h13, 32'h00000080, 5'd0, 0, r);
    run_op(0, 1, 1, 0, 3'd0, 32'h13, 32'h0, 5'd4, 0, r);
    chk("lb_80", r, 32'hFFFFFF80);
    run_op(0, 1, 1, 0, 3'd4, 32'h13, 32'h0, 5'd4, 0, r);
    chk("lbu_80", r, 32'h00000080);
    run_op(0, 1, 1, 0, 3'd2, 32'h10, 32'h0, 5'd4, 0, r);
    chk("lw_merged", r, 32'h80ADBEEF);

    // Misaligned half load faults; memory untouched.
    run_op(0, 1, 1, 0, 3'd1, 32'h11, 32'h0, 5'd5, 0, r);
    run_op(0, 1, 1, 0, 3'd2, 32'h10, 32'h0, 5'd5, 0, r);
    chk("lw_after_fault", r, 32'h80ADBEEF);
    // Misaligned word store faults and must not write.
    run_op(0, 0, 0, 1, 3'd2, 32'h12, 32'h11111111, 5'd0, 0, r);
    run_op(0, 1, 1, 0, 3'd2, 32'h10, 32'h0, 5'd5, 0, r);
    chk("lw_after_bad_sw", r, 32'h80ADBEEF);

    // Non-memory op passes straight through; flush turns it into a bubble.
    run_op(0, 1, 0, 0, 3'd0, 32'h5, 32'h0, 5'd7, 0, r);
    chk("alu_out5", b2.oALUOutW, 32'h5);
    chk("alu_rd7", 32'(b2.oWriteRegW), 32'd7);
    run_op(0, 1, 0, 0, 3'd0, 32'h5, 32'h0, 5'd7, 1, r);

    // A flushed store still commits to RAM.
    run_op(0, 0, 0, 1, 3'd2, 32'h30, 32'hA5A5A5A5, 5'd0, 1, r);
    run_op(0, 1, 1, 0, 3'd2, 32'h30, 32'h0, 5'd6, 0, r);
    chk("lw_flushed_sw", r, 32'hA5A5A5A5);

    // Reset in the first stall cycle abandons the pending store.
    run_op(0, 0, 0, 1, 3'd2, 32'h20, 32'hCAFEF00D, 5'd0, 0, r);
    run_op(0, 1, 1, 0, 3'd2, 32'h20, 32'h0, 5'd9, 0, r);
    drive(0, 0, 0, 1, 3'd2, 32'h20, 32'h12345678, 5'd0, 0);
    #1;
    chk("rst_pre_stall", 32'(b2.oStallM), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk_zero_outputs("rst_mid");
    @(posedge clk); #1;
    chk("rst_hold_stall", 32'(b2.oStallM), 32'd0);
    nop(0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(0, 1, 1, 0, 3'd2, 32'h20, 32'h0, 5'd9, 0, r);
    chk("lw_after_rst", r, 32'hCAFEF00D);

    // Zero wait states: back-to-back store/load, no stall.
    run_op(1, 0, 0, 1, 3'd2, 32'h4, 32'h0BADF00D, 5'd0, 0, r);
    run_op(1, 1, 1, 0, 3'd2, 32'h4, 32'h0, 5'd2, 0, r);
    chk("ws0_lw", r, 32'h0BADF00D);

    // Randomized mix on both instances, including wrapped addresses.
    for (int n = 0; n < 400; n++) begin
      d    = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      case ($urandom_range(0, 7))
        0:       f3 = 3'(3 + 3 * $urandom_range(0, 1) + $urandom_range(0, 1));
        default: begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
          endcase
        end
      endcase
      sz = 1 << (f3 % 4);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      run_op(d, 1'($urandom_range(0, 1)), kind == 1, kind == 2, f3, a, $urandom,
             5'($urandom), $urandom_range(0, 7) == 0, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set data RAM size in 32-bit words (power of two).
REQ-002 Parameter WAIT_STATES, default 1, SHALL set the number of stall cycles per memory access (0 allowed).
REQ-003 iClk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 iRst  in  1  reset, asynchronous, active-high.
REQ-005 iRegWriteM  in  1  M-stage register-write enable.
REQ-006 iMemToRegM  in  1  M-stage load.
REQ-007 iMemWriteM  in  1  M-stage store.
REQ-008 iFunct3M  in  3  width/sign: 0 b, 1 h, 2 w, 4 bu, 5 hu.
REQ-009 iALUOutM  in  32  byte address, or result for non-memory ops.
REQ-010 iWriteDataM  in  32  store data.
REQ-011 iWriteRegM  in  5  destination register.
REQ-012 iFlushW  in  1  bubble request for the W register.
REQ-013 oStallM  out  1  hold M and earlier stages.
REQ-014 oFaultM  out  1  misaligned or illegal-width access this cycle.
REQ-015 oRegWriteW, oMemToRegW  out  1 each; oReadDataW, oALUOutW  out  32 each; oWriteRegW  out  5: W-stage register.

Function
REQ-016 Access = iMemToRegM or iMemWriteM; iMemToRegM and iMemWriteM SHALL NOT both be high (caller guarantee); behaviour if both are high is undefined.
REQ-017 FSM states IDLE, WAIT; counter width SHALL hold WAIT_STATES.
REQ-018 IDLE, valid access, WAIT_STATES>0: oStallM=1, go WAIT, counter=WAIT_STATES-1.
REQ-019 WAIT, counter>0: oStallM=1, counter decrements; counter=0: oStallM=0, access commits, go IDLE.
REQ-020 Access SHALL commit in the cycle oStallM is low; total stall = WAIT_STATES cycles; WAIT_STATES=0 commits in the presenting cycle, no stall.
REQ-021 Non-access instructions SHALL never stall and pass to W in one cycle.
REQ-022 While oStallM=1, the W register SHALL load a bubble (oRegWriteW=0, oMemToRegW=0).
REQ-023 RAM index = iALUOutM[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap).
REQ-024 Store: sb writes lane iALUOutM[1:0] with iWriteDataM[7:0]; sh writes lanes {addr[1],0} and {addr[1],1} with [15:0]; sw writes all lanes; write occurs on the committing edge only.
REQ-025 Load: lb/lh sign-extend, lbu/lhu zero-extend, lw raw; selected lanes per REQ-024; result registered into oReadDataW at commit.
REQ-026 Fault: h/hu with addr[0]=1, w with addr[1:0]!=0, or funct3 in {3,6,7} on an access; oFaultM=1 combinationally that cycle, no stall, no RAM write, W gets bubble.
REQ-027 W register SHALL carry iALUOutM, iWriteRegM, iRegWriteM, iMemToRegM at every non-stalled, non-faulting edge.
REQ-028 iFlushW SHALL force a W bubble at that edge; it SHALL NOT abort an in-progress WAIT, and a committing store under flush SHALL still write RAM.
REQ-029 iFlushW and commit in the same cycle: RAM commit proceeds, W gets bubble.

Reset
REQ-030 iRst high: FSM IDLE, counter 0, all W outputs 0, oStallM 0, oFaultM 0, regardless of clock.
REQ-031 Reset during WAIT SHALL abandon the access; a pending store SHALL NOT write; RAM contents are not cleared.

Structure
REQ-032 Shared pipeline package SHALL hold the funct3 width enum, the FSM state enum, and DEPTH_WORDS/WAIT_STATES defaults.
REQ-033 Lane select plus sign/zero extension SHALL be one sub-module, load_align (combinational); FSM, RAM and W register reside in mem_wb_stage.

Verification (WAIT_STATES=2 unless noted)
REQ-034 sw 0xDEADBEEF @0x10, then lw @0x10 -> oStallM high 2 cycles each; oReadDataW=0xDEADBEEF, oMemToRegW=1.
REQ-035 sb 0x80 @0x13; lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lw @0x10 -> 0x80ADBEEF.
REQ-036 lh @0x11 -> oFaultM=1 one cycle, oStallM=0, oRegWriteW=0, subsequent lw @0x10 unchanged.
REQ-037 ALU op RegWrite=1, ALUOut=0x5, rd=7 -> next edge oALUOutW=0x5, oWriteRegW=7, no stall; same with iFlushW=1 -> oRegWriteW=0.
REQ-038 sw 0x12345678 @0x20, iRst pulsed in first stall cycle -> all outputs 0, FSM IDLE; later lw @0x20 returns prior contents.
REQ-039 WAIT_STATES=0: back-to-back sw/lw @0x4 -> oStallM never high, lw result next edge.
